// File: rtl/rr_ctz_arbiter_if.sv
// Request/grant bundle between the arbiter, its requesters and the shared resource.
// The arbiter side owns the grant outputs; the client side owns req and done.
interface rr_ctz_arbiter_if #(
    parameter int N_REQ = 8,
    parameter int CNT_W = 7
);
    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [2:0]       gnt_id;
    logic [CNT_W-1:0] busy_cycles;
    logic             timeout_err;

    modport master (
        input  req, done,
        output gnt, gnt_valid, gnt_id, busy_cycles, timeout_err
    );

    modport slave (
        output req, done,
        input  gnt, gnt_valid, gnt_id, busy_cycles, timeout_err
    );
endinterface

// File: rtl/rr_ctz_arbiter.sv
// Round-robin arbiter for one non-pipelined resource shared by 8 requesters.
// The winner is found by rotating req by the pointer, counting trailing zeros, then un-rotating.
module rr_ctz_arbiter #(
    parameter int N_REQ   = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input logic                clk,
    input logic                rst_n,
    rr_ctz_arbiter_if.master   bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [2:0]       ptr;
    logic [7:0]       gnt;
    logic [2:0]       gnt_id;
    logic [CNT_W-1:0] busy_cycles;
    logic             timeout_err;

    logic             release_now;
    logic [2:0]       base;
    logic [7:0]       rot;
    logic [3:0]       tz;
    logic             has_win;
    logic [2:0]       win;
    logic             tmo_hit;

    // A done release re-arbitrates in the same cycle from the pointer it is about to write.
    assign release_now = (state == BUSY) && bus.done;
    assign base        = release_now ? gnt_id + 3'd1 : ptr;
    assign tmo_hit     = (state == BUSY) && !bus.done && (busy_cycles == CNT_W'(TIMEOUT - 1));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rot = '0;
        tz  = 4'd8;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = bus.req[3'(i + int'(base))];
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) tz = 4'(i);
        end
    end

    assign has_win = (tz != 4'd8);
    assign win     = base + tz[2:0];

    // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt         <= '0;
            gnt_id      <= '0;
            busy_cycles <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (has_win) begin
                        state       <= BUSY;
                        gnt         <= 8'(1) << win;
                        gnt_id      <= win;
                        busy_cycles <= '0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        ptr <= base;
                        if (has_win) begin
                            gnt         <= 8'(1) << win;
                            gnt_id      <= win;
                            busy_cycles <= '0;
                        end else begin
                            state       <= IDLE;
                            gnt         <= '0;
                            gnt_id      <= '0;
                            busy_cycles <= '0;
                        end
                    end else if (tmo_hit) begin
                        // Forced release: no back-to-back grant, the holder loses priority.
                        timeout_err <= 1'b1;
                        ptr         <= gnt_id + 3'd1;
                        state       <= IDLE;
                        gnt         <= '0;
                        gnt_id      <= '0;
                        busy_cycles <= '0;
                    end else if (busy_cycles != CNT_W'(TIMEOUT)) begin
                        busy_cycles <= busy_cycles + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt         = gnt;
    assign bus.gnt_valid   = |gnt;
    assign bus.gnt_id      = gnt_id;
    assign bus.busy_cycles = busy_cycles;
    assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_rr_ctz_arbiter.sv
// Bench for rr_ctz_arbiter: a scan-based round-robin model compared on every falling edge,
// plus directed scenarios with literal expectations.
module tb_rr_ctz_arbiter;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en   = 1'b0;

    // Model state: who holds the resource, how long, and where priority starts.
    bit m_busy;
    int m_id;
    int m_ptr;
    int m_cnt;
    bit m_terr;

    rr_ctz_arbiter_if #(.N_REQ(8), .CNT_W(CNT_W)) bus ();

    rr_ctz_arbiter #(.N_REQ(8), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First active requester scanning upward from the pointer, or -1.
    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_id = 0; m_ptr = 0; m_cnt = 0; m_terr = 0;
    endtask

    task automatic model_edge(input logic [7:0] r, input bit d);
        int w;
        m_terr = 0;
        if (!m_busy) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin m_busy = 1; m_id = w; m_cnt = 0; end
        end else if (d) begin
            m_ptr = (m_id + 1) % 8;
            w = pick(r, m_ptr);
            if (w >= 0) begin m_id = w; m_cnt = 0; end
            else begin m_busy = 0; m_id = 0; m_cnt = 0; end
        end else if (m_cnt == TIMEOUT - 1) begin
            m_terr = 1; m_ptr = (m_id + 1) % 8; m_busy = 0; m_id = 0; m_cnt = 0;
        end else if (m_cnt < TIMEOUT) begin
            m_cnt++;
        end
    endtask

    // Called at a falling edge: drive inputs, advance model at the rising edge, return at the next fall.
    task automatic cycle(input logic [7:0] r, input bit d);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        model_edge(r, d);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt",         32'(bus.gnt),         m_busy ? (32'd1 << m_id) : 32'd0);
            check("gnt_valid",   32'(bus.gnt_valid),   32'(m_busy));
            check("gnt_id",      32'(bus.gnt_id),      32'(m_id));
            check("busy_cycles", 32'(bus.busy_cycles), 32'(m_cnt));
            check("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
        end
    end

    task automatic do_reset();
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_gnt",   32'(bus.gnt),         32'd0);
        check("rst_id",    32'(bus.gnt_id),      32'd0);
        check("rst_valid", 32'(bus.gnt_valid),   32'd0);
        check("rst_busy",  32'(bus.busy_cycles), 32'd0);
        check("rst_terr",  32'(bus.timeout_err), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        bus.req  = '0;
        bus.done = 1'b0;
        do_reset();

        // Single request, released by done five cycles later.
        cycle(8'h04, 1'b0);
        check("single_gnt", 32'(bus.gnt), 32'h04);
        check("single_id",  32'(bus.gnt_id), 32'd2);
        repeat (3) cycle(8'h00, 1'b0);
        cycle(8'h00, 1'b1);
        check("single_rel", 32'(bus.gnt), 32'h00);
        // done in IDLE is ignored; ptr must still be 3.
        cycle(8'h00, 1'b1);
        cycle(8'h09, 1'b0);
        check("ptr_after_single", 32'(bus.gnt_id), 32'd3);
        cycle(8'h00, 1'b1);

        // Rotation fairness from a fresh pointer.
        do_reset();
        cycle(8'hFF, 1'b0);
        check("rot_first", 32'(bus.gnt_id), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            cycle(8'hFF, 1'b0);
            cycle(8'hFF, 1'b0);
            cycle(8'hFF, 1'b1);
            check("rot_id", 32'(bus.gnt_id), 32'(k % 8));
            check("rot_b2b", 32'(bus.gnt_valid), 32'd1);
        end
        cycle(8'h00, 1'b1);

        // Wrap priority: grant 6, then 7 beats 0, then 0.
        cycle(8'h40, 1'b0);
        check("wrap_6", 32'(bus.gnt_id), 32'd6);
        cycle(8'h81, 1'b1);
        check("wrap_7", 32'(bus.gnt_id), 32'd7);
        cycle(8'h81, 1'b1);
        check("wrap_0", 32'(bus.gnt_id), 32'd0);
        cycle(8'h00, 1'b1);

        // Holder gets lowest priority at release.
        cycle(8'h08, 1'b0);
        check("hold_3", 32'(bus.gnt_id), 32'd3);
        cycle(8'h09, 1'b1);
        check("hold_other", 32'(bus.gnt_id), 32'd0);
        cycle(8'h08, 1'b1);
        check("hold_3b", 32'(bus.gnt_id), 32'd3);
        cycle(8'h08, 1'b1);
        check("hold_regrant", 32'(bus.gnt_id), 32'd3);
        cycle(8'h00, 1'b1);

        // Watchdog: grant 5, no done.
        cycle(8'h20, 1'b0);
        check("tmo_gnt", 32'(bus.gnt_id), 32'd5);
        repeat (TIMEOUT - 1) cycle(8'h00, 1'b0);
        check("tmo_pre_cnt",  32'(bus.busy_cycles), 32'd63);
        check("tmo_pre_terr", 32'(bus.timeout_err), 32'd0);
        cycle(8'h00, 1'b0);
        check("tmo_terr", 32'(bus.timeout_err), 32'd1);
        check("tmo_gnt0", 32'(bus.gnt), 32'd0);
        cycle(8'h00, 1'b0);
        check("tmo_pulse", 32'(bus.timeout_err), 32'd0);
        cycle(8'h41, 1'b0);
        check("tmo_ptr6", 32'(bus.gnt_id), 32'd6);

        // done in the trigger cycle wins over the watchdog.
        repeat (TIMEOUT - 1) cycle(8'h00, 1'b0);
        cycle(8'h00, 1'b1);
        check("tmo_done_terr", 32'(bus.timeout_err), 32'd0);
        check("tmo_done_rel",  32'(bus.gnt_valid), 32'd0);

        // Asynchronous reset in the middle of a grant.
        cycle(8'h02, 1'b0);
        check("pre_arst_id", 32'(bus.gnt_id), 32'd1);
        repeat (3) cycle(8'h00, 1'b0);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_gnt",  32'(bus.gnt), 32'd0);
        check("arst_id",   32'(bus.gnt_id), 32'd0);
        check("arst_busy", 32'(bus.busy_cycles), 32'd0);
        check("arst_vld",  32'(bus.gnt_valid), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        cycle(8'h80, 1'b0);
        check("post_arst_id", 32'(bus.gnt_id), 32'd7);
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
